wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter DATA_SZ_P, 32, data width of the shared wb bus and each requester.
REQ-002 Parameter ADDR_SZ_P, 10, address width of the shared wb bus and each requester.
REQ-003 Parameter TIMEOUT_P, 16, maximum cycles waiting for bus_ack before abort; legal range 2..255.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 req  in  2  per-requester transaction request, bit i = requester i.
REQ-007 cmd  in  2  per-requester command, 1 = write, 0 = read.
REQ-008 addr  in  2*ADDR_SZ_P  per-requester address, requester i in slice i.
REQ-009 wdata  in  2*DATA_SZ_P  per-requester write data, requester i in slice i.
REQ-010 gnt  out  2  one-hot grant to the requester that owns the bus.
REQ-011 done  out  2  one-cycle completion pulse to the granted requester.
REQ-012 err  out  1  one-cycle abort pulse, coincident with done.
REQ-013 rdata  out  DATA_SZ_P  read data returned on completion.
REQ-014 bus_stb  out  1  transaction strobe to the shared bus.
REQ-015 bus_cmd  out  1  command to the bus (wb cmd).
REQ-016 bus_addr  out  ADDR_SZ_P  address to the bus.
REQ-017 bus_data  out  DATA_SZ_P  write data to the bus.
REQ-018 bus_rdata  in  DATA_SZ_P  read data from the bus, valid with bus_ack.
REQ-019 bus_ack  in  1  bus completion, single-cycle.

Function
REQ-020 FSM states: IDLE, BUSY, DONE; IDLE->BUSY when any req bit is 1; BUSY->DONE on bus_ack (or timeout); DONE->IDLE unconditionally.
REQ-021 Arbitration in IDLE: single request wins; both requesting -> winner is the requester not granted last (round robin).
REQ-022 On IDLE->BUSY: gnt, bus_cmd, bus_addr, bus_data are registered from the winner's slice; bus_stb = 1 from the next cycle.
REQ-023 bus_cmd/addr/data and gnt are held stable for all of BUSY and DONE regardless of requester input changes.
REQ-024 bus_ack is sampled only in BUSY; ack outside BUSY is ignored.
REQ-025 On bus_ack in BUSY: bus_stb = 0 next cycle; rdata <= bus_rdata when bus_cmd = 0, otherwise unchanged.
REQ-026 In DONE: done[winner] = 1 for exactly one cycle; gnt is cleared on DONE->IDLE; the last-grant pointer is updated to the winner.
REQ-027 rdata holds its value until the next completed read.
REQ-028 A requester deasserting req during BUSY does not abort; the transaction completes normally.
REQ-029 Minimum transaction occupancy is 3 cycles (IDLE, BUSY, DONE); a requester still asserting req after done re-arbitrates in the following IDLE.

Reset
REQ-030 Reset asserted at any time (including mid-BUSY) forces IDLE immediately and clears gnt, done, err, bus_stb, bus_cmd, bus_addr, bus_data, rdata, and the timeout counter to 0.
REQ-031 The last-grant pointer resets to requester 1, so requester 0 wins the first contention.

Configuration
REQ-032 Macro WB_ARBITER_TIMEOUT_EN defined: an 8-bit counter clears on entry to BUSY and increments each BUSY cycle; if it reaches TIMEOUT_P-1 without ack, the FSM goes to DONE with err = 1, and rdata is unchanged.
REQ-033 If bus_ack arrives in the same cycle the timeout is reached, the ack wins and err = 0.
REQ-034 Macro undefined: no counter is built, err is tied to 0, and BUSY waits indefinitely for bus_ack.

Verification
REQ-035 Single read: req=2'b01, cmd=0, addr0=0x05; ack after 2 cycles with bus_rdata=0xDEADBEEF -> bus_addr=0x05, done=2'b01 once, rdata=0xDEADBEEF, err=0.
REQ-036 Contention: req=2'b11 held continuously, each ack after 1 cycle -> gnt sequence 01,10,01,10; bus_addr alternates between addr0 and addr1.
REQ-037 Write stability: requester 1 write addr=0x3FF, data=0x12345678; change wdata and addr during BUSY -> bus outputs remain 0x3FF/0x12345678 until ack; rdata unchanged.
REQ-038 Mid-transaction reset: assert reset during BUSY -> bus_stb, gnt, and done are 0 in the same cycle; after release, req=2'b11 -> requester 0 granted first.
REQ-039 Timeout (macro defined, TIMEOUT_P=4): no ack -> bus_stb high for 4 cycles, then done and err pulse together, rdata unchanged; ack on the 4th cycle -> err=0.
REQ-040 Stray ack: pulse bus_ack in IDLE -> no done, no state change.

Source files
------------

// File: rtl/wb_arbiter.sv
// Two-requester round-robin arbiter in front of a single Wishbone-style bus.
// Optional bus-ack timeout is built when WB_ARBITER_TIMEOUT_EN is defined.
module wb_arbiter #(
  parameter int DATA_SZ_P = 32,
  parameter int ADDR_SZ_P = 10,
  parameter int TIMEOUT_P = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             req,
  input  logic [1:0]             cmd,
  input  logic [2*ADDR_SZ_P-1:0] addr,
  input  logic [2*DATA_SZ_P-1:0] wdata,
  output logic [1:0]             gnt,
  output logic [1:0]             done,
  output logic                   err,
  output logic [DATA_SZ_P-1:0]   rdata,
  output logic                   bus_stb,
  output logic                   bus_cmd,
  output logic [ADDR_SZ_P-1:0]   bus_addr,
  output logic [DATA_SZ_P-1:0]   bus_data,
  input  logic [DATA_SZ_P-1:0]   bus_rdata,
  input  logic                   bus_ack
);

  if (TIMEOUT_P < 2 || TIMEOUT_P > 255) begin : g_bad_timeout
    $error("wb_arbiter: TIMEOUT_P must be within 2..255");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic                 last;
  logic                 win;
  logic                 timeout_hit;
  logic                 finish_ok;
  logic                 finish_tmo;
  logic [ADDR_SZ_P-1:0] win_addr;
  logic [DATA_SZ_P-1:0] win_data;

  // Round robin: on contention the requester that did not own the bus last wins.
  always_comb begin
    win = 1'b0;
    case (req)
      2'b01:   win = 1'b0;
      2'b10:   win = 1'b1;
      2'b11:   win = ~last;
      default: win = 1'b0;
    endcase
  end

  assign win_addr = win ? addr[2*ADDR_SZ_P-1:ADDR_SZ_P] : addr[ADDR_SZ_P-1:0];
  assign win_data = win ? wdata[2*DATA_SZ_P-1:DATA_SZ_P] : wdata[DATA_SZ_P-1:0];

`ifdef WB_ARBITER_TIMEOUT_EN
  logic [7:0] tmo_cnt;
  logic       err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt <= 8'd0;
    end else if (state == BUSY) begin
      tmo_cnt <= tmo_cnt + 8'd1;
    end else begin
      tmo_cnt <= 8'd0;
    end
  end

  assign timeout_hit = (state == BUSY) && (tmo_cnt == 8'(TIMEOUT_P - 1));

  // An ack arriving on the timeout cycle still completes cleanly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= finish_tmo;
    end
  end

  assign err = err_q;
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

  assign finish_ok  = (state == BUSY) && bus_ack;
  assign finish_tmo = (state == BUSY) && !bus_ack && timeout_hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req) state_nxt = BUSY;
      BUSY:    if (finish_ok || finish_tmo) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bus-side request fields are captured once at grant and frozen until IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt      <= 2'b00;
      done     <= 2'b00;
      rdata    <= '0;
      bus_stb  <= 1'b0;
      bus_cmd  <= 1'b0;
      bus_addr <= '0;
      bus_data <= '0;
      last     <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            gnt      <= win ? 2'b10 : 2'b01;
            bus_cmd  <= cmd[win];
            bus_addr <= win_addr;
            bus_data <= win_data;
            bus_stb  <= 1'b1;
          end
        end
        BUSY: begin
          if (finish_ok || finish_tmo) begin
            bus_stb <= 1'b0;
            done    <= gnt;
          end
          if (finish_ok && !bus_cmd) begin
            rdata <= bus_rdata;
          end
        end
        DONE: begin
          done <= 2'b00;
          gnt  <= 2'b00;
          last <= gnt[1];
        end
        default: begin
          done    <= 2'b00;
          gnt     <= 2'b00;
          bus_stb <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter; the timeout scenario follows
// the same WB_ARBITER_TIMEOUT_EN macro as the design.
module tb_wb_arbiter;
  localparam int DW = 32;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    req;
  logic [1:0]    cmd;
  logic [AW-1:0] a0, a1;
  logic [DW-1:0] w0, w1;
  logic [1:0]    gnt;
  logic [1:0]    done;
  logic          err;
  logic [DW-1:0] rdata;
  logic          bus_stb;
  logic          bus_cmd;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_data;
  logic [DW-1:0] bus_rdata;
  logic          bus_ack;

  int checks = 0;
  int errors = 0;

  wb_arbiter #(.DATA_SZ_P(DW), .ADDR_SZ_P(AW), .TIMEOUT_P(4)) dut (
    .clk(clk), .reset(reset), .req(req), .cmd(cmd),
    .addr({a1, a0}), .wdata({w1, w0}),
    .gnt(gnt), .done(done), .err(err), .rdata(rdata),
    .bus_stb(bus_stb), .bus_cmd(bus_cmd), .bus_addr(bus_addr),
    .bus_data(bus_data), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] r, input logic [1:0] c,
                               input logic [AW-1:0] ad0, input logic [AW-1:0] ad1,
                               input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    req = r;
    cmd = c;
    a0  = ad0;
    a1  = ad1;
    w0  = d0;
    w1  = d1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset     = 1'b1;
    bus_ack   = 1'b0;
    bus_rdata = '0;
    applyStimulus(2'b00, 2'b00, '0, '0, '0, '0);
    tick();
    tick();
    checkOutput("rst_gnt", 64'(gnt), 64'h0);
    checkOutput("rst_done", 64'(done), 64'h0);
    checkOutput("rst_err", 64'(err), 64'h0);
    checkOutput("rst_stb", 64'(bus_stb), 64'h0);
    checkOutput("rst_addr", 64'(bus_addr), 64'h0);
    checkOutput("rst_rdata", 64'(rdata), 64'h0);
    reset = 1'b0;
    tick();

    // Single read from requester 0, ack two cycles after grant
    applyStimulus(2'b01, 2'b00, 10'h005, 10'h000, '0, '0);
    tick();
    checkOutput("rd_gnt", 64'(gnt), 64'h1);
    checkOutput("rd_stb", 64'(bus_stb), 64'h1);
    checkOutput("rd_addr", 64'(bus_addr), 64'h005);
    checkOutput("rd_cmd", 64'(bus_cmd), 64'h0);
    req = 2'b00;
    tick();
    checkOutput("rd_wait_done", 64'(done), 64'h0);
    bus_ack   = 1'b1;
    bus_rdata = 32'hDEADBEEF;
    tick();
    bus_ack = 1'b0;
    checkOutput("rd_done", 64'(done), 64'h1);
    checkOutput("rd_err", 64'(err), 64'h0);
    checkOutput("rd_rdata", 64'(rdata), 64'hDEADBEEF);
    checkOutput("rd_stb_off", 64'(bus_stb), 64'h0);
    tick();
    checkOutput("rd_done_once", 64'(done), 64'h0);
    checkOutput("rd_gnt_clr", 64'(gnt), 64'h0);

    // Stray ack while idle
    bus_ack   = 1'b1;
    bus_rdata = 32'h11111111;
    tick();
    tick();
    bus_ack = 1'b0;
    checkOutput("stray_done", 64'(done), 64'h0);
    checkOutput("stray_stb", 64'(bus_stb), 64'h0);
    checkOutput("stray_gnt", 64'(gnt), 64'h0);
    checkOutput("stray_rdata", 64'(rdata), 64'hDEADBEEF);

    // Requester 1 write; inputs change while the transaction is in flight
    applyStimulus(2'b10, 2'b10, 10'h000, 10'h3FF, '0, 32'h12345678);
    tick();
    checkOutput("wr_gnt", 64'(gnt), 64'h2);
    checkOutput("wr_cmd", 64'(bus_cmd), 64'h1);
    applyStimulus(2'b00, 2'b00, 10'h000, 10'h001, '0, 32'h0);
    tick();
    tick();
    checkOutput("wr_hold_addr", 64'(bus_addr), 64'h3FF);
    checkOutput("wr_hold_data", 64'(bus_data), 64'h12345678);
    checkOutput("wr_hold_cmd", 64'(bus_cmd), 64'h1);
    bus_ack   = 1'b1;
    bus_rdata = 32'hBAD0BAD0;
    tick();
    bus_ack = 1'b0;
    checkOutput("wr_done", 64'(done), 64'h2);
    checkOutput("wr_rdata", 64'(rdata), 64'hDEADBEEF);
    checkOutput("wr_done_addr", 64'(bus_addr), 64'h3FF);
    tick();

    // Contention with both requests held
    applyStimulus(2'b11, 2'b00, 10'h010, 10'h020, '0, '0);
    for (int k = 0; k < 4; k++) begin
      tick();
      checkOutput("rr_gnt", 64'(gnt), (k % 2 == 0) ? 64'h1 : 64'h2);
      checkOutput("rr_addr", 64'(bus_addr), (k % 2 == 0) ? 64'h010 : 64'h020);
      bus_ack   = 1'b1;
      bus_rdata = 32'hA0000000 + 32'(k);
      tick();
      bus_ack = 1'b0;
      checkOutput("rr_done", 64'(done), (k % 2 == 0) ? 64'h1 : 64'h2);
      tick();
      checkOutput("rr_idle_gnt", 64'(gnt), 64'h0);
    end
    req = 2'b00;
    checkOutput("rr_rdata", 64'(rdata), 64'hA0000003);

    // No ack: timeout build aborts, default build keeps waiting
    applyStimulus(2'b01, 2'b00, 10'h02A, 10'h000, '0, '0);
    tick();
    req = 2'b00;
`ifdef WB_ARBITER_TIMEOUT_EN
    for (int c = 0; c < 3; c++) begin
      checkOutput("tmo_stb", 64'(bus_stb), 64'h1);
      tick();
    end
    checkOutput("tmo_stb4", 64'(bus_stb), 64'h1);
    tick();
    checkOutput("tmo_done", 64'(done), 64'h1);
    checkOutput("tmo_err", 64'(err), 64'h1);
    checkOutput("tmo_stb_off", 64'(bus_stb), 64'h0);
    checkOutput("tmo_rdata", 64'(rdata), 64'hA0000003);
    tick();
    checkOutput("tmo_err_once", 64'(err), 64'h0);
    req = 2'b01;
    tick();
    req = 2'b00;
    tick();
    tick();
    tick();
    bus_ack   = 1'b1;
    bus_rdata = 32'h55AA55AA;
    tick();
    bus_ack = 1'b0;
    checkOutput("tmo_ack_done", 64'(done), 64'h1);
    checkOutput("tmo_ack_err", 64'(err), 64'h0);
    checkOutput("tmo_ack_rdata", 64'(rdata), 64'h55AA55AA);
    tick();
`else
    for (int c = 0; c < 10; c++) begin
      tick();
      checkOutput("wait_stb", 64'(bus_stb), 64'h1);
      checkOutput("wait_done", 64'(done), 64'h0);
    end
    bus_ack   = 1'b1;
    bus_rdata = 32'h55AA55AA;
    tick();
    bus_ack = 1'b0;
    checkOutput("wait_ack_done", 64'(done), 64'h1);
    checkOutput("wait_ack_err", 64'(err), 64'h0);
    checkOutput("wait_ack_rdata", 64'(rdata), 64'h55AA55AA);
    tick();
`endif

    // Leave requester 0 as last owner, then reset in the middle of a requester 1 transfer
    applyStimulus(2'b01, 2'b00, 10'h001, 10'h002, '0, '0);
    tick();
    req     = 2'b00;
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    tick();
    req = 2'b10;
    tick();
    checkOutput("mr_gnt_pre", 64'(gnt), 64'h2);
    req   = 2'b00;
    reset = 1'b1;
    #1;
    checkOutput("mr_stb", 64'(bus_stb), 64'h0);
    checkOutput("mr_gnt", 64'(gnt), 64'h0);
    checkOutput("mr_done", 64'(done), 64'h0);
    checkOutput("mr_rdata", 64'(rdata), 64'h0);
    tick();
    reset = 1'b0;
    req   = 2'b11;
    tick();
    checkOutput("mr_first_gnt", 64'(gnt), 64'h1);
    checkOutput("mr_first_addr", 64'(bus_addr), 64'h001);
    req     = 2'b00;
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
